// File: rtl/sblk_feeder_if.sv
// Stream, config and tile write-port bundle for the SuperBlock loader.
// The slave side is the feeder; the master side is the upstream producer and tile array.
interface sblk_feeder_if #(
  parameter int unsigned NTILE    = 4,
  parameter int unsigned W_BIT    = 16,
  parameter int unsigned ACT_BIT  = 16,
  parameter int unsigned DATA_BIT = 16,
  parameter int unsigned LEN_BIT  = 10
) ();
  localparam int unsigned CW = LEN_BIT + $clog2(NTILE);

  logic                     cfg_start;
  logic                     cfg_mode;
  logic [LEN_BIT-1:0]       cfg_len;
  logic                     cfg_abort;
  logic [DATA_BIT-1:0]      in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [NTILE*W_BIT-1:0]   w_wr_data;
  logic [NTILE-1:0]         w_wr_en;
  logic [NTILE*ACT_BIT-1:0] act_wr_data;
  logic [NTILE-1:0]         act_wr_en;
  logic                     busy;
  logic                     done;
  logic [CW-1:0]            word_cnt;

  modport master (
    output cfg_start, cfg_mode, cfg_len, cfg_abort, in_data, in_valid,
    input  in_ready, w_wr_data, w_wr_en, act_wr_data, act_wr_en, busy, done, word_cnt
  );

  modport slave (
    input  cfg_start, cfg_mode, cfg_len, cfg_abort, in_data, in_valid,
    output in_ready, w_wr_data, w_wr_en, act_wr_data, act_wr_en, busy, done, word_cnt
  );
endinterface

// File: rtl/sblk_feeder.sv
// SuperBlock loader: spreads one valid/ready word stream round-robin over NTILE
// tile weight or activation write ports, with start/abort control in clk_l.
module sblk_feeder #(
  parameter int unsigned NTILE    = 4,
  parameter int unsigned W_BIT    = 16,
  parameter int unsigned ACT_BIT  = 16,
  parameter int unsigned DATA_BIT = 16,
  parameter int unsigned LEN_BIT  = 10
) (
  input logic         clk_l,
  input logic         rst_n,
  sblk_feeder_if.slave bus
);
  localparam int unsigned PW = $clog2(NTILE);
  localparam int unsigned CW = LEN_BIT + PW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          mode;
  logic [CW-1:0] total;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr;
  logic          start_acc;
  logic          beat;
  logic          last_beat;

  always_ff @(posedge clk_l) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // An aborted cycle never counts as a beat, so its word is dropped outright.
  always_comb begin
    start_acc    = (state == IDLE) && bus.cfg_start;
    beat         = (state == LOAD) && bus.in_valid && !bus.cfg_abort;
    last_beat    = beat && ((cnt + CW'(1)) == total);
    state_nx     = state;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.word_cnt = cnt;
    case (state)
      IDLE: begin
        if (start_acc) begin
          state_nx = (bus.cfg_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (bus.cfg_abort) begin
          state_nx = IDLE;
        end else if (last_beat) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Config, word counter and tile pointer.
  always_ff @(posedge clk_l) begin
    if (!rst_n) begin
      mode  <= 1'b0;
      total <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else if (start_acc) begin
      mode  <= bus.cfg_mode;
      total <= CW'(bus.cfg_len) * CW'(NTILE);
      cnt   <= '0;
      ptr   <= '0;
    end else if (beat) begin
      cnt <= cnt + CW'(1);
      if (ptr == PW'(NTILE - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PW'(1);
      end
    end
  end

  // Registered write ports: enables are single-cycle, data slices hold until rewritten.
  always_ff @(posedge clk_l) begin
    if (!rst_n) begin
      bus.w_wr_en     <= '0;
      bus.act_wr_en   <= '0;
      bus.w_wr_data   <= '0;
      bus.act_wr_data <= '0;
    end else begin
      bus.w_wr_en   <= '0;
      bus.act_wr_en <= '0;
      if (beat) begin
        for (int unsigned t = 0; t < NTILE; t++) begin
          if (ptr == PW'(t)) begin
            if (!mode) begin
              bus.w_wr_en[t]                    <= 1'b1;
              bus.w_wr_data[t*W_BIT +: W_BIT]   <= bus.in_data[W_BIT-1:0];
            end else begin
              bus.act_wr_en[t]                     <= 1'b1;
              bus.act_wr_data[t*ACT_BIT +: ACT_BIT] <= bus.in_data[ACT_BIT-1:0];
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sblk_feeder.sv
// Bench for sblk_feeder: a reference model queues expected tile writes at each
// accepted beat; a monitor pops and compares them one cycle later.
module tb_sblk_feeder;
  localparam int unsigned NT = 4;
  localparam int unsigned WB = 16;
  localparam int unsigned DB = 20;
  localparam int unsigned LB = 10;
  localparam int unsigned CWT = LB + 2;

  typedef enum int {M_IDLE, M_LOAD, M_DONE} mst_t;
  typedef struct packed {
    logic        mode;
    logic [1:0]  tile;
    logic [15:0] data;
  } wr_t;

  logic clk_l = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_l = ~clk_l;

  sblk_feeder_if #(.NTILE(NT), .W_BIT(WB), .ACT_BIT(WB), .DATA_BIT(DB), .LEN_BIT(LB)) bus ();

  sblk_feeder #(.NTILE(NT), .W_BIT(WB), .ACT_BIT(WB), .DATA_BIT(DB), .LEN_BIT(LB)) dut (
    .clk_l (clk_l),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model, advanced on each rising edge from the driven inputs.
  mst_t       m_st = M_IDLE;
  logic       m_mode;
  int         m_total;
  int         m_cnt = 0;
  int         m_ptr = 0;
  int         m_rst_gen = 0;
  wr_t        q[$];

  always @(posedge clk_l) begin
    if (!rst_n) begin
      m_st = M_IDLE;
      m_cnt = 0;
      m_ptr = 0;
      m_rst_gen++;
    end else begin
      case (m_st)
        M_IDLE: if (bus.cfg_start) begin
          m_mode  = bus.cfg_mode;
          m_total = int'(bus.cfg_len) * NT;
          m_cnt   = 0;
          m_ptr   = 0;
          m_st    = (bus.cfg_len == 0) ? M_DONE : M_LOAD;
        end
        M_LOAD: begin
          if (bus.cfg_abort) begin
            m_st = M_IDLE;
          end else if (bus.in_valid) begin
            q.push_back('{mode: m_mode, tile: 2'(m_ptr), data: bus.in_data[15:0]});
            m_ptr = (m_ptr + 1) % NT;
            m_cnt++;
            if (m_cnt == m_total) m_st = M_DONE;
          end
        end
        default: m_st = M_IDLE;
      endcase
    end
  end

  // Monitor: compares every output on the falling edge.
  logic        armed = 1'b0;
  int          mon_gen = 0;
  logic [63:0] m_w = '0;
  logic [63:0] m_a = '0;
  int          nw = 0, na = 0, nd = 0, nr = 0;

  always @(negedge clk_l) begin
    logic [3:0] ew, ea;
    wr_t        e;
    ew = '0;
    ea = '0;
    if (mon_gen != m_rst_gen) begin
      mon_gen = m_rst_gen;
      m_w = '0;
      m_a = '0;
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      if (!e.mode) begin
        ew[e.tile] = 1'b1;
        m_w[e.tile*16 +: 16] = e.data;
      end else begin
        ea[e.tile] = 1'b1;
        m_a[e.tile*16 +: 16] = e.data;
      end
    end
    if (armed) begin
      chk("w_wr_en",     64'(bus.w_wr_en),   64'(ew));
      chk("act_wr_en",   64'(bus.act_wr_en), 64'(ea));
      chk("w_wr_data",   bus.w_wr_data,      m_w);
      chk("act_wr_data", bus.act_wr_data,    m_a);
      chk("in_ready",    64'(bus.in_ready),  64'(m_st == M_LOAD));
      chk("busy",        64'(bus.busy),      64'(m_st == M_LOAD));
      chk("done",        64'(bus.done),      64'(m_st == M_DONE));
      chk("word_cnt",    64'(bus.word_cnt),  64'(m_cnt));
      if (bus.w_wr_en != 0)   nw++;
      if (bus.act_wr_en != 0) na++;
      if (bus.done)           nd++;
      if (bus.in_ready)       nr++;
    end
  end

  task automatic cyc();
    @(posedge clk_l);
    #1;
  endtask

  task automatic start(input logic mode, input int len);
    bus.cfg_start = 1'b1;
    bus.cfg_mode  = mode;
    bus.cfg_len   = LB'(len);
    cyc();
    bus.cfg_start = 1'b0;
  endtask

  int bw, ba, bd, br;
  task automatic snap();
    bw = nw; ba = na; bd = nd; br = nr;
  endtask

  task automatic weight_load(input string tag, input logic [19:0] base);
    snap();
    start(1'b0, 2);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = base + 20'(i);
      cyc();
    end
    bus.in_valid = 1'b0;
    cyc(); cyc();
    chk({tag, "_w_pulses"}, 64'(nw - bw), 64'd8);
    chk({tag, "_a_pulses"}, 64'(na - ba), 64'd0);
    chk({tag, "_done"},     64'(nd - bd), 64'd1);
    chk({tag, "_ready"},    64'(nr - br), 64'd8);
    chk({tag, "_cnt"},      64'(bus.word_cnt), 64'd8);
  endtask

  initial begin
    bus.cfg_start = 1'b0;
    bus.cfg_mode  = 1'b0;
    bus.cfg_len   = '0;
    bus.cfg_abort = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    cyc();
    armed = 1'b1;
    cyc();
    chk("rst_outputs", {bus.w_wr_en, bus.act_wr_en, bus.in_ready, bus.busy, bus.done, 52'(bus.word_cnt)}, '0);
    chk("rst_data", bus.w_wr_data | bus.act_wr_data, '0);
    rst_n = 1'b1;
    cyc();

    // Weight load of 8 words; upper input bits are junk and must be dropped.
    weight_load("wload", 20'hF0010);
    chk("wload_data", bus.w_wr_data, 64'h0013_0012_0011_0010 + 64'h0004_0004_0004_0004);

    // Activation load with bubbles.
    snap();
    start(1'b1, 1);
    for (int i = 0; i < 6; i++) begin
      logic [5:0] pat;
      pat = 6'b110101;
      bus.in_valid = pat[i];
      bus.in_data  = 20'hF00A0 + 20'(i);
      cyc();
    end
    bus.in_valid = 1'b0;
    cyc(); cyc();
    chk("act_pulses", 64'(na - ba), 64'd4);
    chk("act_w_none", 64'(nw - bw), 64'd0);
    chk("act_done",   64'(nd - bd), 64'd1);
    chk("act_data",   bus.act_wr_data, 64'h00A5_00A4_00A2_00A0);
    chk("act_w_held", bus.w_wr_data,   64'h0017_0016_0015_0014);

    // Zero length.
    snap();
    start(1'b0, 0);
    chk("zero_done_now", 64'(bus.done), 64'd1);
    cyc(); cyc();
    chk("zero_done", 64'(nd - bd), 64'd1);
    chk("zero_ready", 64'(nr - br), 64'd0);
    chk("zero_en", 64'((nw - bw) + (na - ba)), 64'd0);

    // Abort after 3 beats with a beat offered in the abort cycle.
    snap();
    start(1'b0, 4);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 20'h00030 + 20'(i);
      cyc();
    end
    bus.cfg_abort = 1'b1;
    bus.in_data   = 20'h00033;
    cyc();
    bus.cfg_abort = 1'b0;
    bus.in_valid  = 1'b0;
    chk("abort_idle", 64'(bus.busy), 64'd0);
    cyc(); cyc();
    chk("abort_pulses", 64'(nw - bw), 64'd3);
    chk("abort_done",   64'(nd - bd), 64'd0);
    chk("abort_data",   bus.w_wr_data, 64'h0017_0032_0031_0030);
    start(1'b0, 1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 20'h00040 + 20'(i);
      cyc();
    end
    bus.in_valid = 1'b0;
    cyc();
    chk("restart_data", bus.w_wr_data, 64'h0043_0042_0041_0040);

    // Reset in the middle of a load.
    snap();
    start(1'b1, 2);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 20'h00050 + 20'(i);
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    chk("mrst_outputs", {bus.w_wr_en, bus.act_wr_en, bus.in_ready, bus.busy, bus.done, 52'(bus.word_cnt)}, '0);
    chk("mrst_data", bus.w_wr_data | bus.act_wr_data, '0);
    cyc(); cyc();
    chk("mrst_pulses", 64'(na - ba), 64'd5);
    chk("mrst_done",   64'(nd - bd), 64'd0);
    weight_load("post_rst", 20'h00060);
    chk("post_rst_data", bus.w_wr_data, 64'h0067_0066_0065_0064);

    // Start pulsed mid-transfer with a different mode and length is ignored.
    snap();
    start(1'b0, 1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.cfg_start = (i == 1);
      bus.cfg_mode  = 1'b1;
      bus.cfg_len   = LB'(3);
      bus.in_data   = 20'h00070 + 20'(i);
      cyc();
    end
    bus.cfg_start = 1'b0;
    bus.in_valid  = 1'b0;
    cyc(); cyc();
    chk("ign_w_pulses", 64'(nw - bw), 64'd4);
    chk("ign_a_pulses", 64'(na - ba), 64'd0);
    chk("ign_done",     64'(nd - bd), 64'd1);
    chk("ign_cnt",      64'(bus.word_cnt), 64'd4);
    chk("ign_data",     bus.w_wr_data, 64'h0073_0072_0071_0070);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
